// File: rtl/gray_to_rgb_pkg.sv
// rtl/gray_to_rgb_pkg.sv - shared types and constants for the grayscale-to-RGB expander
package gray_to_rgb_pkg;

  typedef enum logic [1:0] {
    MAP_REPLICATE,
    MAP_INVERT,
    MAP_HEAT,
    MAP_THRESHOLD
  } colour_map_t;

  localparam logic [7:0] HEAT_BP1 = 8'd85;
  localparam logic [7:0] HEAT_BP2 = 8'd170;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/gray_colormap.sv
// rtl/gray_colormap.sv - combinational gray-to-RGB colour map
// Heat ramps are exact: 3*(g-bp) tops out at 255 inside each band, so no clamp is needed.
module gray_colormap
  import gray_to_rgb_pkg::*;
(
  input  logic [7:0]  i_gray,
  input  colour_map_t i_map,
  input  logic [7:0]  i_threshold,
  output rgb_t        o_rgb
);

  logic [9:0] w_tri;

  always_comb begin
    w_tri = '0;
    o_rgb = '0;
    case (i_map)
      MAP_REPLICATE: o_rgb = '{r: i_gray, g: i_gray, b: i_gray};
      MAP_INVERT:    o_rgb = '{r: ~i_gray, g: ~i_gray, b: ~i_gray};
      MAP_HEAT: begin
        if (i_gray < HEAT_BP1) begin
          w_tri   = 10'(i_gray) * 10'd3;
          o_rgb.r = 8'(w_tri);
        end else if (i_gray < HEAT_BP2) begin
          w_tri   = 10'(i_gray - HEAT_BP1) * 10'd3;
          o_rgb.r = 8'hFF;
          o_rgb.g = 8'(w_tri);
        end else begin
          w_tri   = 10'(i_gray - HEAT_BP2) * 10'd3;
          o_rgb.r = 8'hFF;
          o_rgb.g = 8'hFF;
          o_rgb.b = 8'(w_tri);
        end
      end
      MAP_THRESHOLD: o_rgb = (i_gray >= i_threshold) ? '{r: 8'hFF, g: 8'hFF, b: 8'hFF} : '0;
      default:       o_rgb = '0;
    endcase
  end

endmodule

// File: rtl/gray_to_rgb_stream.sv
// rtl/gray_to_rgb_stream.sv - two-stage grayscale-to-RGB pixel stream with frame markers
// Both stages share one advance enable, so s_ready depends only on m_valid/m_ready.
module gray_to_rgb_stream
  import gray_to_rgb_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] s_gray,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [1:0] mode,
  input  logic [7:0] threshold,
  output logic [7:0] m_r,
  output logic [7:0] m_g,
  output logic [7:0] m_b,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  colour_map_t   r_mode_q;
  logic [7:0]    r_thr_q;

  logic          r_s1_valid, r_s1_sof, r_s1_eol, r_s1_eof;
  logic [7:0]    r_s1_gray, r_s1_thr;
  colour_map_t   r_s1_map;

  logic          r_s2_valid, r_s2_sof, r_s2_eol, r_s2_eof;
  rgb_t          r_s2_rgb;

  logic          w_en, w_in_xfer, w_at_origin, w_last_x, w_last_y;
  colour_map_t   w_frame_map;
  logic [7:0]    w_frame_thr;
  rgb_t          w_rgb;

  assign w_en        = !r_s2_valid || m_ready;
  assign w_in_xfer   = s_valid && w_en;
  assign w_at_origin = (r_x == '0) && (r_y == '0);
  assign w_last_x    = (r_x == XW'(WIDTH - 1));
  assign w_last_y    = (r_y == YW'(HEIGHT - 1));
  // The origin pixel must already see the controls it is latching.
  assign w_frame_map = w_at_origin ? colour_map_t'(mode) : r_mode_q;
  assign w_frame_thr = w_at_origin ? threshold : r_thr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_y      <= '0;
      r_mode_q <= MAP_REPLICATE;
      r_thr_q  <= '0;
    end else if (w_in_xfer) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
      if (w_at_origin) begin
        r_mode_q <= colour_map_t'(mode);
        r_thr_q  <= threshold;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid <= 1'b0;
      r_s1_gray  <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
      r_s1_map   <= MAP_REPLICATE;
      r_s1_thr   <= '0;
    end else if (w_en) begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_s1_gray <= s_gray;
        r_s1_sof  <= w_at_origin;
        r_s1_eol  <= w_last_x;
        r_s1_eof  <= w_last_x && w_last_y;
        r_s1_map  <= w_frame_map;
        r_s1_thr  <= w_frame_thr;
      end
    end
  end

  gray_colormap u_colormap (
    .i_gray      (r_s1_gray),
    .i_map       (r_s1_map),
    .i_threshold (r_s1_thr),
    .o_rgb       (w_rgb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid <= 1'b0;
      r_s2_rgb   <= '0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_eof   <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2_rgb <= w_rgb;
      r_s2_sof   <= r_s1_valid && r_s1_sof;
      r_s2_eol   <= r_s1_valid && r_s1_eol;
      r_s2_eof   <= r_s1_valid && r_s1_eof;
    end
  end

  assign s_ready = w_en;
  assign m_valid = r_s2_valid;
  assign m_r     = r_s2_rgb.r;
  assign m_g     = r_s2_rgb.g;
  assign m_b     = r_s2_rgb.b;
  assign m_sof   = r_s2_sof;
  assign m_eol   = r_s2_eol;
  assign m_eof   = r_s2_eof;

endmodule

// File: tb/tb_gray_to_rgb_stream.sv
// tb/tb_gray_to_rgb_stream.sv - self-checking bench for gray_to_rgb_stream
// Expected pixels come from a per-frame colour-map model indexed by accepted-pixel count.
module tb_gray_to_rgb_stream;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] s_gray;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic [7:0] m_r, m_g, m_b;
  logic       m_valid, m_ready, m_sof, m_eol, m_eof;

  gray_to_rgb_stream #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .resetn(resetn), .s_gray(s_gray), .s_valid(s_valid), .s_ready(s_ready),
    .mode(mode), .threshold(threshold), .m_r(m_r), .m_g(m_g), .m_b(m_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gray;
    int         mode;
    logic [7:0] r, g, b;
    logic       sof, eol, eof;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   acc_k = 0, f_mode = 0, f_thr = 0, cyc = 0;

  logic       o_valid, o_sready, o_sof, o_eol, o_eof, o_xfer, o_acc;
  logic [7:0] o_r, o_g, o_b;
  int         o_step;

  task automatic model_accept(input int gray, input int in_mode, input int in_thr);
    exp_t e;
    int x, y, r, g, b;
    x = acc_k % W;
    y = (acc_k / W) % H;
    if (x == 0 && y == 0) begin
      f_mode = in_mode;
      f_thr  = in_thr;
    end
    case (f_mode)
      0: begin r = gray; g = gray; b = gray; end
      1: begin r = 255 - gray; g = 255 - gray; b = 255 - gray; end
      2: begin
        if (gray < 85)       begin r = 3 * gray; g = 0; b = 0; end
        else if (gray < 170) begin r = 255; g = 3 * (gray - 85); b = 0; end
        else                 begin r = 255; g = 255; b = 3 * (gray - 170); end
      end
      default: begin r = (gray >= f_thr) ? 255 : 0; g = r; b = r; end
    endcase
    e.gray = gray; e.mode = f_mode;
    e.r = 8'(r); e.g = 8'(g); e.b = 8'(b);
    e.sof = (x == 0 && y == 0);
    e.eol = (x == W - 1);
    e.eof = (x == W - 1) && (y == H - 1);
    e.step = cyc;
    exp_q.push_back(e);
    acc_k++;
  endtask

  // One clock: drive inputs at the falling edge, snapshot outputs, then cross the rising edge.
  task automatic step(input bit v, input int gray, input int md, input int thr, input bit mr);
    s_valid = v; s_gray = 8'(gray); mode = 2'(md); threshold = 8'(thr); m_ready = mr;
    #1;
    o_valid = m_valid; o_sready = s_ready; o_r = m_r; o_g = m_g; o_b = m_b;
    o_sof = m_sof; o_eol = m_eol; o_eof = m_eof;
    o_xfer = m_valid && m_ready;
    o_acc  = s_valid && s_ready;
    o_step = cyc;
    @(posedge clk);
    if (o_acc) model_accept(gray, md, thr);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; s_gray = '0; mode = '0; threshold = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m_valid, m_r, m_g, m_b, m_sof, m_eol, m_eof, s_ready} !== {1'b0, 24'h0, 3'b000, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got v=%b rgb=%h%h%h m=%b%b%b rdy=%b want v=0 rgb=000000 m=000 rdy=1",
               m_valid, m_r, m_g, m_b, m_sof, m_eol, m_eof, s_ready);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_valid, s_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_release: got v=%b rdy=%b want v=0 rdy=1", m_valid, s_ready);
    end
  endtask

  task automatic test_replicate();
    exp_t e;
    int   j = 0;
    for (int i = 0; i < 40 && (i < 8 || exp_q.size() > 0); i++) begin
      step(i < 8, i, 0, 0, 1'b1);
      if (o_xfer) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL repl_extra: output with no pending pixel"); end
        else begin
          e = exp_q.pop_front();
          if ({o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {e.r, e.g, e.b, e.sof, e.eol, e.eof}) begin
            n_err++;
            $display("FAIL repl_pix: got %h%h%h %b%b%b want %h%h%h %b%b%b", o_r, o_g, o_b, o_sof, o_eol, o_eof,
                     e.r, e.g, e.b, e.sof, e.eol, e.eof);
          end
          n_cmp++;
          if (o_step - e.step != 2) begin n_err++; $display("FAIL repl_latency: got %0d want 2", o_step - e.step); end
          n_cmp++;
          if ({o_r, o_sof, o_eol, o_eof} !== {8'(j), j == 0, j % 4 == 3, j == 7}) begin
            n_err++;
            $display("FAIL repl_const: got r=%0d m=%b%b%b want r=%0d for pixel %0d", o_r, o_sof, o_eol, o_eof, j, j);
          end
          j++;
        end
      end
    end
    n_cmp++;
    if (j != 8 || exp_q.size() != 0) begin n_err++; $display("FAIL repl_drain: got %0d outputs want 8", j); end
  endtask

  task automatic test_heat();
    exp_t       e;
    logic [23:0] want;
    bit          known;
    for (int i = 0; i < 300 && (i < 256 || exp_q.size() > 0); i++) begin
      step(i < 256, i, 2, 0, 1'b1);
      if (o_xfer) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL heat_extra: output with no pending pixel"); end
        else begin
          e = exp_q.pop_front();
          if ({o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {e.r, e.g, e.b, e.sof, e.eol, e.eof}) begin
            n_err++;
            $display("FAIL heat_pix: gray=%0d got %h%h%h %b%b%b want %h%h%h %b%b%b", e.gray, o_r, o_g, o_b,
                     o_sof, o_eol, o_eof, e.r, e.g, e.b, e.sof, e.eol, e.eof);
          end
          known = 1'b1;
          case (e.gray)
            84:      want = 24'hFC0000;
            85:      want = 24'hFF0000;
            169:     want = 24'hFFFC00;
            170:     want = 24'hFFFF00;
            255:     want = 24'hFFFFFF;
            default: begin want = 24'h0; known = 1'b0; end
          endcase
          if (known) begin
            n_cmp++;
            if ({o_r, o_g, o_b} !== want) begin
              n_err++;
              $display("FAIL heat_bp: gray=%0d got %h%h%h want %h", e.gray, o_r, o_g, o_b, want);
            end
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL heat_drain: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_threshold();
    exp_t e;
    int   gtab[16];
    int   j = 0;
    gtab = '{127, 128, 0, 255, 129, 126, 7, 250, 3, 100, 200, 128, 64, 1, 254, 90};
    for (int i = 0; i < 50 && (i < 16 || exp_q.size() > 0); i++) begin
      step(i < 16, (i < 16) ? gtab[i] : 0, (i < 2) ? 3 : 1, (i < 2) ? 128 : 0, 1'b1);
      if (o_xfer) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL thr_extra: output with no pending pixel"); end
        else begin
          e = exp_q.pop_front();
          if ({o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {e.r, e.g, e.b, e.sof, e.eol, e.eof}) begin
            n_err++;
            $display("FAIL thr_pix: gray=%0d got %h%h%h %b%b%b want %h%h%h %b%b%b", e.gray, o_r, o_g, o_b,
                     o_sof, o_eol, o_eof, e.r, e.g, e.b, e.sof, e.eol, e.eof);
          end
          if (j == 0 || j == 1 || j == 2 || j == 8) begin
            n_cmp++;
            if (o_r !== ((j == 0 || j == 2) ? 8'h00 : (j == 1) ? 8'hFF : 8'(255 - gtab[8]))) begin
              n_err++;
              $display("FAIL thr_frame_latch: pixel %0d got r=%h", j, o_r);
            end
          end
          j++;
        end
      end
    end
    n_cmp++;
    if (j != 16 || exp_q.size() != 0) begin n_err++; $display("FAIL thr_drain: got %0d outputs want 16", j); end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         sent = 0, n_sof = 0, n_eof = 0;
    bit         v, mr, prev_stall = 1'b0;
    logic [26:0] prev_out = '0;
    for (int i = 0; i < 3000 && (sent < 24 || exp_q.size() > 0); i++) begin
      v  = (sent < 24) && ($urandom_range(0, 9) < 7);
      mr = $urandom_range(0, 9) < 6;
      step(v, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), mr);
      if (o_acc) sent++;
      n_cmp++;
      if (o_sready !== (!o_valid || mr)) begin
        n_err++;
        $display("FAIL rand_sready: got %b want %b", o_sready, !o_valid || mr);
      end
      if (!o_valid && (o_sof || o_eol || o_eof)) begin
        n_err++;
        $display("FAIL rand_marker_idle: got %b%b%b want 000", o_sof, o_eol, o_eof);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({o_valid, o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {1'b1, prev_out}) begin
          n_err++;
          $display("FAIL rand_stall: got %b %h want 1 %h", o_valid, {o_r, o_g, o_b, o_sof, o_eol, o_eof}, prev_out);
        end
      end
      prev_stall = o_valid && !mr;
      prev_out   = {o_r, o_g, o_b, o_sof, o_eol, o_eof};
      if (o_xfer) begin
        n_cmp++;
        n_sof += int'(o_sof);
        n_eof += int'(o_eof);
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_extra: output with no pending pixel"); end
        else begin
          e = exp_q.pop_front();
          if ({o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {e.r, e.g, e.b, e.sof, e.eol, e.eof}) begin
            n_err++;
            $display("FAIL rand_pix: gray=%0d mode=%0d got %h%h%h %b%b%b want %h%h%h %b%b%b", e.gray, e.mode,
                     o_r, o_g, o_b, o_sof, o_eol, o_eof, e.r, e.g, e.b, e.sof, e.eol, e.eof);
          end
        end
      end
    end
    n_cmp++;
    if (sent != 24 || exp_q.size() != 0 || n_sof != 3 || n_eof != 3) begin
      n_err++;
      $display("FAIL rand_totals: got sent=%0d pend=%0d sof=%0d eof=%0d want 24 0 3 3", sent, exp_q.size(), n_sof, n_eof);
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    int   j = 0;
    step(1'b1, 10, 1, 0, 1'b1);
    step(1'b1, 20, 1, 0, 1'b1);
    s_valid = 1'b1; s_gray = 8'd30;
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_sof, m_eol, m_eof, s_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL rst_async: got v=%b m=%b%b%b rdy=%b want v=0 m=000 rdy=1", m_valid, m_sof, m_eol, m_eof, s_ready);
    end
    exp_q.delete();
    acc_k = 0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 40 && (i < 8 || exp_q.size() > 0); i++) begin
      step(i < 8, 40 + 25 * i, 2, 0, 1'b1);
      if (o_xfer) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rst_extra: output with no pending pixel"); end
        else begin
          e = exp_q.pop_front();
          if ({o_r, o_g, o_b, o_sof, o_eol, o_eof} !== {e.r, e.g, e.b, e.sof, e.eol, e.eof}) begin
            n_err++;
            $display("FAIL rst_pix: gray=%0d got %h%h%h %b%b%b want %h%h%h %b%b%b", e.gray, o_r, o_g, o_b,
                     o_sof, o_eol, o_eof, e.r, e.g, e.b, e.sof, e.eol, e.eof);
          end
          if (j == 0) begin
            n_cmp++;
            if ({o_sof, o_r, o_g, o_b} !== {1'b1, 24'h780000}) begin
              n_err++;
              $display("FAIL rst_first: got sof=%b rgb=%h%h%h want sof=1 rgb=780000", o_sof, o_r, o_g, o_b);
            end
          end
          j++;
        end
      end
    end
    n_cmp++;
    if (j != 8 || exp_q.size() != 0) begin n_err++; $display("FAIL rst_drain: got %0d outputs want 8", j); end
  endtask

  initial begin
    test_reset();
    test_replicate();
    test_heat();
    test_threshold();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_to_rgb_stream.md
# gray_to_rgb_stream

Streaming pixel expander that accepts 8-bit grayscale pixels over a valid/ready interface and emits 24-bit RGB pixels with frame/line markers, applying a per-frame selectable colour map. It undoes the RGB→grayscale reduction on the display side: grayscale frames from the processing pipeline pass through it before the RGB video output or framebuffer writer.

## Interface
- `WIDTH`, default 640: active pixels per line.
- `HEIGHT`, default 480: lines per frame.

- `clk` in 1: single system clock; all logic rising-edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `s_gray` in 8: input grayscale pixel.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: block accepts input this cycle.
- `mode` in 2: colour map. 0 = replicate, 1 = invert, 2 = heat, 3 = threshold.
- `threshold` in 8: threshold level for mode 3.
- `m_r`, `m_g`, `m_b` out 8 each: output RGB pixel.
- `m_valid` out 1: output pixel valid.
- `m_ready` in 1: downstream accepts output.
- `m_sof` out 1: output pixel is (x=0, y=0).
- `m_eol` out 1: output pixel is x=WIDTH-1.
- `m_eof` out 1: output pixel is (WIDTH-1, HEIGHT-1).

## Operation
- Input transfer occurs when `s_valid && s_ready`. Output transfer occurs when `m_valid && m_ready`.
- Position counters x and y (widths `$clog2(WIDTH)` and `$clog2(HEIGHT)`) track the next accepted input pixel.
  - x increments on each input transfer and wraps to 0 after WIDTH-1, which increments y.
  - y wraps to 0 after HEIGHT-1.
- Frame-latched controls:
  - `mode` and `threshold` are sampled into mode_q/thr_q on the input transfer at (0,0).
  - That frame's pixels, including the (0,0) pixel, use the sampled values.
  - Changes to `mode`/`threshold` mid-frame have no effect until the next frame.
- Colour maps, with g = gray:
  - Replicate: r = g, g = g, b = g.
  - Invert: each channel = 255 − g.
  - Heat:
    - g < 85: (3g, 0, 0).
    - 85 ≤ g < 170: (255, 3(g−85), 0).
    - g ≥ 170: (255, 255, 3(g−170)).
  - Products use 10-bit intermediates and are exact. The maximum is 255, so no saturation is needed.
  - Threshold: g ≥ thr_q → (255, 255, 255), else (0, 0, 0).
- Markers `m_sof`/`m_eol`/`m_eof` travel with their pixel through the pipeline. They are never asserted while `m_valid` is low.
- Reset mid-frame:
  - Clears counters, mode_q (to replicate), thr_q (to 0), and all stage-valid bits.
  - Any in-flight pixels are discarded.
  - The next accepted pixel is (0,0).

## Timing
- Two-stage pipeline with a common advance enable: en = !m_valid || m_ready.
  - Stage 1 registers gray, position flags and mode_q/thr_q.
  - Stage 2 registers the mapped RGB and the markers.
- `s_ready` = en. It is combinational from `m_ready` and `m_valid`, with no combinational path from `s_valid`.
- Latency: the pixel accepted at cycle n appears on `m_*` at cycle n+2 when `m_ready` is held high. Throughput is 1 pixel/cycle.
- Backpressure: while `m_ready` is low and `m_valid` is high, every `m_*` output and stage 1 hold steady, and `s_ready` is low.
  - Once `m_valid` rises, it stays high until a transfer occurs.
- Bubbles: stage valid bits propagate zeros when `s_valid` is low. A partially filled pipeline drains when en is high.
- Reset values: `m_r`/`m_g`/`m_b` = 0, `m_valid` = 0, `m_sof`/`m_eol`/`m_eof` = 0.
  - `s_ready` = 1 in reset, since en is true when `m_valid` = 0.

## Structure
- Package `gray_to_rgb_pkg` holds:
  - `typedef enum logic [1:0] {MAP_REPLICATE, MAP_INVERT, MAP_HEAT, MAP_THRESHOLD} colour_map_t`.
  - Constants `HEAT_BP1 = 85`, `HEAT_BP2 = 170`.
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_t`.
- One combinational sub-module `gray_colormap`: inputs gray, colour_map_t and threshold; output rgb_t. It is instantiated between stage 1 and stage 2.
- The top level contains the counters, control latching, pipeline registers and handshake.

## Test plan
- Replicate mode, WIDTH=4, HEIGHT=2, stream 0..7 with `m_ready`=1 → outputs (k,k,k) two cycles after each input. `m_sof` on pixel 0, `m_eol` on pixels 3 and 7, `m_eof` on pixel 7.
- Heat mode, sweep gray 0..255 → 84→(252,0,0), 85→(255,0,0), 169→(255,252,0), 170→(255,255,0), 255→(255,255,255). Every value matches a software model.
- Threshold mode with thr=128: 127→(0,0,0), 128→(255,255,255). Change `mode` to invert mid-frame → no effect until the next (0,0) pixel, which outputs 255−g.
- Random `s_valid`/`m_ready` toggling over 3 frames → no pixel lost or duplicated, output order preserved, `m_*` stable while stalled, marker count exactly 3 `m_sof` and 3 `m_eof`.
- Assert `resetn` low mid-line at x=2 → `m_valid`=0 immediately (async). After release, the next accepted pixel carries `m_sof`=1 and mode reverts to replicate until resampled.
